// File: rtl/tft_pkg.sv
// Shared definitions for the TFT requester arbiter: FSM states and command bit positions.
package tft_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2,
    ST_DROP = 2'd3
  } state_e;

  localparam int unsigned CMD_W     = 3;
  localparam int unsigned CMD_INIT  = 0;
  localparam int unsigned CMD_CLEAR = 1;
  localparam int unsigned CMD_DRAW  = 2;

  // Keep only the highest-priority (lowest-numbered) command bit.
  function automatic logic [CMD_W-1:0] cmd_select(input logic [CMD_W-1:0] call);
    cmd_select = '0;
    if (call[CMD_INIT])       cmd_select[CMD_INIT]  = 1'b1;
    else if (call[CMD_CLEAR]) cmd_select[CMD_CLEAR] = 1'b1;
    else if (call[CMD_DRAW])  cmd_select[CMD_DRAW]  = 1'b1;
  endfunction

endpackage

// File: rtl/tft_wdogmod.sv
// Saturating 20-bit busy-cycle watchdog; expired is a registered flag raised
// the cycle after the count sits at TIMEOUT-1 while enabled.
module tft_wdogmod #(
  parameter logic [19:0] TIMEOUT = 20'd1_000_000
) (
  input  logic CLOCK,
  input  logic RESET,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam logic [19:0] LAST = TIMEOUT - 20'd1;

  logic [19:0] cnt_q, cnt_d;
  logic        expired_q, expired_d;

  always_comb begin
    cnt_d     = cnt_q;
    expired_d = 1'b0;
    if (clear) begin
      cnt_d = '0;
    end else if (enable) begin
      if (cnt_q == LAST) expired_d = 1'b1;
      else               cnt_d     = cnt_q + 20'd1;
    end
  end

  always_ff @(posedge CLOCK) begin
    if (!RESET) begin
      cnt_q     <= '0;
      expired_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      expired_q <= expired_d;
    end
  end

  assign expired = expired_q;

endmodule

// File: rtl/tft_arbmod.sv
// Round-robin arbiter between two TFT requesters and the TFT base module,
// with per-transaction timeout abort reported through oErr.
module tft_arbmod
  import tft_pkg::*;
#(
  parameter logic [19:0] TIMEOUT = 20'd1_000_000
) (
  input  logic       CLOCK,
  input  logic       RESET,
  input  logic [2:0] iCallA,
  output logic       oDoneA,
  input  logic [2:0] iCallB,
  output logic       oDoneB,
  output logic [2:0] oCall,
  input  logic       iDone,
  output logic       oErr
);

  state_e     state_q, state_d;
  logic [2:0] call_q, call_d;
  logic       done_a_q, done_a_d;
  logic       done_b_q, done_b_d;
  logic       err_q, err_d;
  logic       grant_b_q, grant_b_d;
  logic       last_b_q, last_b_d;
  logic       pick_b;
  logic       wd_clear, wd_enable, wd_expired;

  tft_wdogmod #(.TIMEOUT(TIMEOUT)) u_wdog (
    .CLOCK   (CLOCK),
    .RESET   (RESET),
    .clear   (wd_clear),
    .enable  (wd_enable),
    .expired (wd_expired)
  );

  always_comb begin
    state_d   = state_q;
    call_d    = call_q;
    done_a_d  = 1'b0;
    done_b_d  = 1'b0;
    err_d     = 1'b0;
    grant_b_d = grant_b_q;
    last_b_d  = last_b_q;
    pick_b    = 1'b0;
    wd_clear  = 1'b0;
    wd_enable = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if ((|iCallA) || (|iCallB)) begin
          // On contention the requester not served last wins.
          pick_b    = (|iCallB) && (!(|iCallA) || !last_b_q);
          grant_b_d = pick_b;
          call_d    = cmd_select(pick_b ? iCallB : iCallA);
          wd_clear  = 1'b1;
          state_d   = ST_BUSY;
        end
      end
      ST_BUSY: begin
        wd_enable = 1'b1;
        if (iDone || wd_expired) begin
          call_d   = '0;
          done_a_d = !grant_b_q;
          done_b_d = grant_b_q;
          err_d    = !iDone;
          state_d  = ST_DONE;
        end
      end
      ST_DONE: begin
        last_b_d = grant_b_q;
        state_d  = ST_DROP;
      end
      ST_DROP: begin
        if ((grant_b_q ? iCallB : iCallA) == 3'b000) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLOCK) begin
    if (!RESET) begin
      state_q   <= ST_IDLE;
      call_q    <= '0;
      done_a_q  <= 1'b0;
      done_b_q  <= 1'b0;
      err_q     <= 1'b0;
      grant_b_q <= 1'b0;
      last_b_q  <= 1'b1;
    end else begin
      state_q   <= state_d;
      call_q    <= call_d;
      done_a_q  <= done_a_d;
      done_b_q  <= done_b_d;
      err_q     <= err_d;
      grant_b_q <= grant_b_d;
      last_b_q  <= last_b_d;
    end
  end

  assign oCall  = call_q;
  assign oDoneA = done_a_q;
  assign oDoneB = done_b_q;
  assign oErr   = err_q;

endmodule

// File: tb/tb_tft_arbmod.sv
// Bench for tft_arbmod: fixed vector table, directed corner sequences and
// random traffic, all cross-checked against a transaction-level model.
module tb_tft_arbmod;

  localparam int TMO = 16;

  logic       CLOCK = 1'b0;
  logic       RESET;
  logic [2:0] iCallA, iCallB, oCall;
  logic       iDone, oDoneA, oDoneB, oErr;

  int vectors = 0;
  int miscompares = 0;

  tft_arbmod #(.TIMEOUT(20'd16)) dut (
    .CLOCK  (CLOCK),
    .RESET  (RESET),
    .iCallA (iCallA),
    .oDoneA (oDoneA),
    .iCallB (iCallB),
    .oDoneB (oDoneB),
    .oCall  (oCall),
    .iDone  (iDone),
    .oErr   (oErr)
  );

  initial forever #5 CLOCK = ~CLOCK;

  // Transaction model: who owns the bus, how long it has been serving,
  // whether a completion is being reported, whether we await release.
  int         m_owner;   // 0 none, 1 A, 2 B
  int         m_age;
  bit         m_serving, m_reporting, m_draining, m_last_b;
  logic [2:0] m_call;
  logic       m_da, m_db, m_err;

  function automatic logic [2:0] lowest_bit(input logic [2:0] c);
    for (int i = 0; i < 3; i++)
      if (c[i]) return 3'(1 << i);
    return 3'b000;
  endfunction

  task automatic model_step(input logic [2:0] a, b, input logic d, r);
    logic take_b;
    m_da = 1'b0; m_db = 1'b0; m_err = 1'b0;
    if (!r) begin
      m_owner = 0; m_age = 0; m_serving = 0; m_reporting = 0;
      m_draining = 0; m_last_b = 1; m_call = 3'b000;
    end else if (m_serving) begin
      if (d || m_age == TMO) begin
        m_serving = 0; m_reporting = 1; m_call = 3'b000;
        m_da = (m_owner == 1); m_db = (m_owner == 2); m_err = !d;
      end else begin
        m_age++;
      end
    end else if (m_reporting) begin
      m_reporting = 0; m_draining = 1; m_last_b = (m_owner == 2);
    end else if (m_draining) begin
      if (((m_owner == 1) ? a : b) == 3'b000) begin
        m_draining = 0; m_owner = 0;
      end
    end else if (a != 3'b000 || b != 3'b000) begin
      if (a != 3'b000 && b != 3'b000) take_b = !m_last_b;
      else                            take_b = (b != 3'b000);
      m_owner = take_b ? 2 : 1;
      m_call = lowest_bit(take_b ? b : a);
      m_age = 0;
      m_serving = 1;
    end
  endtask

  task automatic check(input string name, input logic [2:0] ec, input logic eda, edb, eerr);
    vectors++;
    if ({oCall, oDoneA, oDoneB, oErr} !== {ec, eda, edb, eerr}) begin
      miscompares++;
      $display("FAIL %s: got call=%b da=%b db=%b err=%b, want call=%b da=%b db=%b err=%b",
               name, oCall, oDoneA, oDoneB, oErr, ec, eda, edb, eerr);
    end
  endtask

  task automatic cyc(input logic [2:0] a, b, input logic d, r);
    iCallA = a; iCallB = b; iDone = d; RESET = r;
    @(posedge CLOCK);
    model_step(a, b, d, r);
    #1;
    check("model", m_call, m_da, m_db, m_err);
  endtask

  typedef struct {
    logic [2:0] a, b;
    logic       d, r;
    logic [2:0] ec;
    logic       eda, edb, eerr;
  } vec_t;

  function automatic vec_t v(input logic [2:0] a, b, input logic d, r,
                             input logic [2:0] ec, input logic eda, edb, eerr);
    vec_t t;
    t.a = a; t.b = b; t.d = d; t.r = r; t.ec = ec; t.eda = eda; t.edb = edb; t.eerr = eerr;
    return t;
  endfunction

  vec_t tbl[19];

  initial begin
    RESET = 1'b0; iCallA = '0; iCallB = '0; iDone = 1'b0;

    tbl[0]  = v(3'b000, 3'b000, 0, 0, 3'b000, 0, 0, 0);
    tbl[1]  = v(3'b000, 3'b000, 0, 1, 3'b000, 0, 0, 0);
    tbl[2]  = v(3'b000, 3'b110, 0, 1, 3'b010, 0, 0, 0);
    tbl[3]  = v(3'b000, 3'b100, 0, 1, 3'b010, 0, 0, 0);
    tbl[4]  = v(3'b000, 3'b100, 1, 1, 3'b000, 0, 1, 0);
    tbl[5]  = v(3'b000, 3'b100, 0, 1, 3'b000, 0, 0, 0);
    tbl[6]  = v(3'b000, 3'b100, 0, 1, 3'b000, 0, 0, 0);
    tbl[7]  = v(3'b000, 3'b000, 0, 1, 3'b000, 0, 0, 0);
    tbl[8]  = v(3'b101, 3'b000, 0, 1, 3'b001, 0, 0, 0);
    tbl[9]  = v(3'b101, 3'b000, 1, 1, 3'b000, 1, 0, 0);
    tbl[10] = v(3'b000, 3'b000, 0, 1, 3'b000, 0, 0, 0);
    tbl[11] = v(3'b000, 3'b000, 0, 1, 3'b000, 0, 0, 0);
    tbl[12] = v(3'b100, 3'b110, 0, 1, 3'b010, 0, 0, 0);
    tbl[13] = v(3'b100, 3'b110, 1, 1, 3'b000, 0, 1, 0);
    tbl[14] = v(3'b100, 3'b000, 0, 1, 3'b000, 0, 0, 0);
    tbl[15] = v(3'b100, 3'b000, 0, 1, 3'b000, 0, 0, 0);
    tbl[16] = v(3'b100, 3'b000, 0, 1, 3'b100, 0, 0, 0);
    tbl[17] = v(3'b100, 3'b000, 0, 0, 3'b000, 0, 0, 0);
    tbl[18] = v(3'b000, 3'b000, 0, 1, 3'b000, 0, 0, 0);

    for (int i = 0; i < 19; i++) begin
      cyc(tbl[i].a, tbl[i].b, tbl[i].d, tbl[i].r);
      check($sformatf("tbl%0d", i), tbl[i].ec, tbl[i].eda, tbl[i].edb, tbl[i].eerr);
    end

    // Request in cycle 5, oCall in cycle 6, iDone in cycle 20, oDoneA in cycle 21.
    cyc(3'b000, 3'b000, 0, 0);
    for (int c = 1; c <= 4; c++) cyc(3'b000, 3'b000, 0, 1);
    cyc(3'b010, 3'b000, 0, 1);
    check("c6_call", 3'b010, 0, 0, 0);
    for (int c = 6; c <= 19; c++) cyc(3'b010, 3'b000, 0, 1);
    check("c20_hold", 3'b010, 0, 0, 0);
    cyc(3'b010, 3'b000, 1, 1);
    check("c21_done", 3'b000, 1, 0, 0);
    cyc(3'b000, 3'b000, 0, 1);
    cyc(3'b000, 3'b000, 0, 1);

    // Round-robin after reset: A, then B, then A again.
    cyc(3'b000, 3'b000, 0, 0);
    cyc(3'b000, 3'b000, 0, 1);
    cyc(3'b001, 3'b100, 0, 1);
    check("rr_a_first", 3'b001, 0, 0, 0);
    cyc(3'b001, 3'b100, 1, 1);
    check("rr_a_done", 3'b000, 1, 0, 0);
    cyc(3'b000, 3'b100, 0, 1);
    cyc(3'b000, 3'b100, 0, 1);
    check("rr_b_wait", 3'b000, 0, 0, 0);
    cyc(3'b000, 3'b100, 0, 1);
    check("rr_b_next", 3'b100, 0, 0, 0);
    cyc(3'b000, 3'b100, 1, 1);
    check("rr_b_done", 3'b000, 0, 1, 0);
    cyc(3'b000, 3'b000, 0, 1);
    cyc(3'b000, 3'b000, 0, 1);
    cyc(3'b010, 3'b001, 0, 1);
    check("rr_a_again", 3'b010, 0, 0, 0);
    cyc(3'b010, 3'b001, 1, 1);
    cyc(3'b000, 3'b000, 0, 1);
    cyc(3'b000, 3'b000, 0, 1);

    // Timeout: pulse 17 cycles after oCall valid; iDone on that cycle suppresses oErr.
    cyc(3'b001, 3'b000, 0, 1);
    check("to_grant", 3'b001, 0, 0, 0);
    for (int i = 1; i <= 17; i++) begin
      cyc(3'b001, 3'b000, 0, 1);
      if (i == 16) check("to_not_yet", 3'b001, 0, 0, 0);
      if (i == 17) check("to_err", 3'b000, 1, 0, 1);
    end
    cyc(3'b000, 3'b000, 0, 1);
    cyc(3'b000, 3'b000, 0, 1);
    cyc(3'b000, 3'b100, 0, 1);
    check("to2_grant", 3'b100, 0, 0, 0);
    for (int i = 1; i <= 17; i++) cyc(3'b000, 3'b100, (i == 17), 1);
    check("to2_done_wins", 3'b000, 0, 1, 0);
    cyc(3'b000, 3'b000, 0, 1);
    cyc(3'b000, 3'b000, 0, 1);

    // Reset in BUSY aborts silently.
    cyc(3'b100, 3'b000, 0, 1);
    check("rst_grant", 3'b100, 0, 0, 0);
    cyc(3'b100, 3'b000, 0, 1);
    cyc(3'b100, 3'b000, 1, 0);
    check("rst_abort", 3'b000, 0, 0, 0);
    cyc(3'b000, 3'b000, 1, 1);
    check("rst_after", 3'b000, 0, 0, 0);

    // iDone in DROP ignored; held request is not re-granted until released.
    cyc(3'b001, 3'b000, 0, 1);
    cyc(3'b001, 3'b000, 1, 1);
    check("hold_done", 3'b000, 1, 0, 0);
    for (int i = 0; i < 10; i++) cyc(3'b001, 3'b000, 1, 1);
    check("hold_no_regrant", 3'b000, 0, 0, 0);
    cyc(3'b000, 3'b000, 0, 1);
    cyc(3'b000, 3'b000, 0, 1);
    check("hold_released", 3'b000, 0, 0, 0);
    cyc(3'b001, 3'b000, 0, 1);
    check("hold_regrant", 3'b001, 0, 0, 0);

    for (int i = 0; i < 3000; i++) begin
      logic [2:0] ra, rb;
      ra = ($urandom_range(1) == 0) ? 3'b000 : 3'($urandom_range(7));
      rb = ($urandom_range(1) == 0) ? 3'b000 : 3'($urandom_range(7));
      cyc(ra, rb, ($urandom_range(7) == 0), ($urandom_range(199) != 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/tft_arbmod.md
TFT_ARBMOD -- requirements
Module: tft_arbmod

Interface
REQ-001 SHALL have parameter TIMEOUT, default 20'd1_000_000, meaning the maximum number of cycles in BUSY without iDone before abort.
REQ-002 SHALL have port CLOCK, input, 1, the single system clock.
REQ-003 SHALL have port RESET, input, 1; reset is synchronous and active-low.
REQ-004 SHALL have port iCallA, input, 3, requester A command (bit0 init, bit1 clear, bit2 draw); nonzero means request.
REQ-005 SHALL have port oDoneA, output, 1, one-cycle completion pulse to A.
REQ-006 SHALL have port iCallB, input, 3, requester B command, same encoding as iCallA.
REQ-007 SHALL have port oDoneB, output, 1, one-cycle completion pulse to B.
REQ-008 SHALL have port oCall, output, 3, command to the TFT base module.
REQ-009 SHALL have port iDone, input, 1, one-cycle completion pulse from the TFT base module.
REQ-010 SHALL have port oErr, output, 1, one-cycle pulse coincident with oDoneA/oDoneB when the transaction timed out.

Function
REQ-011 SHALL implement four states: IDLE, BUSY, DONE, DROP; all outputs registered.
REQ-012 IDLE: with no request, stay in IDLE, oCall=0; with a request, latch the winner and its command at the clock edge and enter BUSY, so oCall is valid the next cycle (latency 1).
REQ-013 Command latched = lowest set bit of the winner's iCall (priority encode); other bits discarded.
REQ-014 Arbitration SHALL be round-robin: a 1-bit last-served flag; on a simultaneous A and B request the requester not served last wins; after reset A has priority.
REQ-015 BUSY: hold oCall at the latched value, ignoring any change of the requesters' iCall; count cycles from 0.
REQ-016 BUSY with iDone=1: enter DONE, oCall=0 from the next cycle.
REQ-017 BUSY with count reaching TIMEOUT-1 and iDone=0: enter DONE with the error flag set; oCall=0 from the next cycle.
REQ-018 If iDone and the timeout occur in the same cycle, iDone SHALL win (no error).
REQ-019 DONE, exactly one cycle: pulse the granted requester's oDone; pulse oErr if flagged; update last-served; then enter DROP.
REQ-020 DROP: wait until the granted requester's iCall==0, then enter IDLE; the other requester's pending request is arbitrated in IDLE on the following cycle.
REQ-021 iDone seen in IDLE, DONE or DROP SHALL be ignored.
REQ-022 The timeout counter SHALL be 20 bits, clear on BUSY entry, and never wrap.

Reset
REQ-023 While RESET=0 at a clock edge: state=IDLE, oCall=0, oDoneA=0, oDoneB=0, oErr=0, counter=0, last-served=B (A favoured), error flag=0.
REQ-024 Reset asserted mid-transaction SHALL abort immediately; no oDone or oErr pulse is generated for the aborted transaction.

Structure
REQ-025 State encodings and command bit positions (CMD_INIT=0, CMD_CLEAR=1, CMD_DRAW=2) SHALL live in shared package tft_pkg.
REQ-026 The timeout counter SHALL be a sub-module tft_wdogmod (inputs clear/enable, output expired); all other logic is in tft_arbmod.
REQ-027 tft_arbmod SHALL sit between requesters and the TFT base module, driving its iCall and consuming its oDone.

Verification
REQ-028 Bench SHALL cover: A issues iCallA=3'b010 at cycle 5 -> oCall=3'b010 at cycle 6; iDone at cycle 20 -> oDoneA=1 at cycle 21, oCall=0 at cycle 21, oErr=0.
REQ-029 Bench SHALL cover: A and B request in the same cycle after reset -> A served first; B served next after A drops iCallA; a second simultaneous request -> A served first again, because B was served last.
REQ-030 Bench SHALL cover: iCallB=3'b110 -> oCall=3'b010; B changes iCallB to 3'b100 during BUSY -> oCall stays 3'b010.
REQ-031 Bench SHALL cover: TIMEOUT=16, no iDone -> oDone and oErr pulse together 17 cycles after oCall goes valid; iDone on the timeout cycle -> oDone only, oErr=0.
REQ-032 Bench SHALL cover: RESET=0 during BUSY -> next cycle oCall=0 with no oDone pulse; iDone in DROP -> ignored; requester holds iCall 10 cycles after oDone -> no re-grant until it is released.
